// File: rtl/organ_keyscan_pkg.sv
// Shared types and constants for the organ key matrix scanner and the note path.
package organ_pkg;
  localparam int NOTE_W   = 3;
  localparam int KEY_ROWS = 2;
  localparam int KEY_COLS = 4;
  localparam int POS_W    = 3;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [POS_W-1:0]  key_pos_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } keyscan_state_t;

  localparam note_t NOTE_NONE = '0;

  // Matrix positions 0..6 are notes 1..7.
  function automatic note_t pos_to_note(input key_pos_t pos);
    return note_t'(pos + key_pos_t'(1));
  endfunction
endpackage

// File: rtl/organ_keyscan_if.sv
// Key matrix and debounced note signals; slave = scanner side, master = board/consumer side.
interface organ_keyscan_if;
  import organ_pkg::*;

  logic [KEY_ROWS-1:0] row;
  logic [KEY_COLS-1:0] col;
  note_t               value;
  logic                pressed;
  // key_evt is a single-cycle strobe with no back-pressure: the consumer must take it when it fires.
  logic                key_evt;
  keyscan_state_t      dbg_state;

  modport slave  (output row, value, pressed, key_evt, dbg_state, input col);
  modport master (input row, value, pressed, key_evt, dbg_state, output col);
endinterface

// File: rtl/organ_keyscan_sync.sv
// key_sync: parameterised-width 2-flop synchroniser with async active-low reset to IDLE_VAL.
module key_sync #(
  parameter int           W        = 1,
  parameter logic [W-1:0] IDLE_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_VAL;
      sync_q <= IDLE_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/organ_keyscan.sv
// 2x4 organ key matrix scanner with per-frame debounce producing a 0..7 note code.
// Optional KEYSCAN_GHOST_REJECT_EN: multi-key frames read as no key (held key kept while HELD).
module organ_keyscan
  import organ_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  organ_keyscan_if.slave  kbd
);
  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DB_LAST   = 4'(DEBOUNCE_FRAMES);

  logic [KEY_COLS-1:0] col_sync;
  key_sync #(.W(KEY_COLS), .IDLE_VAL({KEY_COLS{1'b1}})) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kbd.col),
    .q_o   (col_sync)
  );

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                row_sel_q, row_sel_d;
  logic [KEY_COLS-1:0] row0_act_q, row0_act_d;
  keyscan_state_t      state_q, state_d;
  key_pos_t            cand_q, cand_d;
  logic [3:0]          cnt_q, cnt_d;
  note_t               value_q, value_d;
  logic                pressed_q, pressed_d;
  logic                evt_q, evt_d;

  logic       slot_end, frame_end;
  logic [7:0] act;
  logic       raw_vld, ghost, match, eff_vld, eff_match;
  key_pos_t   raw_pos;
  logic [3:0] cnt_inc;

  // Sampling on the last slot cycle gives the synchroniser time to settle after each row change.
  always_comb begin
    slot_end   = (slot_q == SLOT_LAST);
    frame_end  = slot_end && row_sel_q;
    slot_d     = slot_end ? '0 : slot_q + 1'b1;
    row_sel_d  = slot_end ? ~row_sel_q : row_sel_q;
    row0_act_d = (slot_end && !row_sel_q) ? ~col_sync : row0_act_q;
  end

  always_comb begin
    act     = {~col_sync, row0_act_q};
    raw_vld = 1'b0;
    raw_pos = '0;
    for (int p = 7; p >= 0; p--) begin
      if (act[p] && p != 7) begin
        raw_vld = 1'b1;
        raw_pos = key_pos_t'(p);
      end
    end
`ifdef KEYSCAN_GHOST_REJECT_EN
    ghost = ((act[6:0] & (act[6:0] - 7'd1)) != 7'd0);
`else
    ghost = 1'b0;
`endif
    match     = raw_vld && (raw_pos == cand_q);
    eff_vld   = raw_vld && !ghost;
    eff_match = match && !ghost;
    cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    pressed_d = pressed_q;
    evt_d     = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (eff_vld) begin
            cand_d = raw_pos;
            cnt_d  = 4'd1;
            if (DB_LAST == 4'd1) begin
              state_d   = HELD;
              value_d   = pos_to_note(raw_pos);
              pressed_d = 1'b1;
              evt_d     = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (eff_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              state_d   = HELD;
              value_d   = pos_to_note(cand_q);
              pressed_d = 1'b1;
              evt_d     = 1'b1;
              cnt_d     = '0;
            end
          end else if (!eff_vld) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cand_d = raw_pos;
            cnt_d  = 4'd1;
          end
        end
        HELD: begin
          if (!(match || ghost)) begin
            cnt_d = 4'd1;
            if (DB_LAST == 4'd1) begin
              state_d   = IDLE;
              value_d   = NOTE_NONE;
              pressed_d = 1'b0;
              evt_d     = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          // A different key here only counts toward release; it is never adopted as cand.
          if (eff_match) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              state_d   = IDLE;
              value_d   = NOTE_NONE;
              pressed_d = 1'b0;
              evt_d     = 1'b1;
              cnt_d     = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      row_sel_q  <= 1'b0;
      row0_act_q <= '0;
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      value_q    <= NOTE_NONE;
      pressed_q  <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      row_sel_q  <= row_sel_d;
      row0_act_q <= row0_act_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      pressed_q  <= pressed_d;
      evt_q      <= evt_d;
    end
  end

  assign kbd.row       = row_sel_q ? 2'b01 : 2'b10;
  assign kbd.value     = value_q;
  assign kbd.pressed   = pressed_q;
  assign kbd.key_evt   = evt_q;
  assign kbd.dbg_state = state_q;
endmodule

// File: tb/tb_organ_keyscan.sv
// Bench for organ_keyscan: board matrix model, frame-level reference model, per-cycle output checks.
module tb_organ_keyscan;
  localparam int DF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  organ_keyscan_if kbd ();

  organ_keyscan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbd   (kbd)
  );

  // Board: pressed keys pull their column low while their row is driven low.
  logic [7:0] key_mask = 8'h00;
  logic       col_force_en = 1'b1;
  logic [3:0] col_force = 4'h0;
  always_comb begin
    if (col_force_en)      kbd.col = col_force;
    else if (!kbd.row[0])  kbd.col = ~key_mask[3:0];
    else if (!kbd.row[1])  kbd.col = ~key_mask[7:4];
    else                   kbd.col = 4'hF;
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: accepted note plus run/miss counters over whole frames.
  logic       m_pressed;
  logic [2:0] m_value;
  logic       m_evt;
  int         m_cand, m_run, m_miss;

  task automatic model_reset();
    m_pressed = 1'b0;
    m_value   = 3'd0;
    m_evt     = 1'b0;
    m_cand    = -1;
    m_run     = 0;
    m_miss    = 0;
  endtask

  task automatic model_frame(input logic [7:0] keys);
    int raw;
    int nact;
    raw  = -1;
    nact = 0;
    for (int p = 0; p < 7; p++) begin
      if (keys[p]) begin
        nact++;
        if (raw < 0) raw = p;
      end
    end
`ifdef KEYSCAN_GHOST_REJECT_EN
    if (nact >= 2) raw = (m_pressed && m_miss == 0) ? m_cand : -1;
`endif
    m_evt = 1'b0;
    if (!m_pressed) begin
      if (raw < 0) m_run = 0;
      else if (m_run > 0 && raw == m_cand) m_run++;
      else begin
        m_cand = raw;
        m_run  = 1;
      end
      if (m_run >= DF) begin
        m_pressed = 1'b1;
        m_value   = 3'(m_cand + 1);
        m_evt     = 1'b1;
        m_run     = 0;
        m_miss    = 0;
      end
    end else begin
      if (raw == m_cand) m_miss = 0;
      else m_miss++;
      if (m_miss >= DF) begin
        m_pressed = 1'b0;
        m_value   = 3'd0;
        m_evt     = 1'b1;
        m_miss    = 0;
        m_run     = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] exp_row, input logic exp_evt);
    check({tag, "_row"},     8'(kbd.row),     8'(exp_row));
    check({tag, "_value"},   8'(kbd.value),   8'(m_value));
    check({tag, "_pressed"}, 8'(kbd.pressed), 8'(m_pressed));
    check({tag, "_evt"},     8'(kbd.key_evt), 8'(exp_evt));
  endtask

  // Called at a negedge in the first slot of a frame; returns at the first slot of the next frame.
  task automatic run_frame(input string tag, input logic [7:0] keys);
    key_mask = keys;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 8) begin
        check_outputs(tag, (k < 4) ? 2'b10 : 2'b01, 1'b0);
      end else begin
        model_frame(keys);
        check_outputs(tag, 2'b10, m_evt);
      end
    end
  endtask

  task automatic hold_reset(input string tag, input int cycles);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_outputs(tag, 2'b10, 1'b0);
      check({tag, "_state"}, 8'(kbd.dbg_state), 8'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset with all columns pulled low.
    @(negedge clk);
    hold_reset("reset", 3);
    col_force_en = 1'b0;

    // Clean press at position 2, six frames.
    for (int f = 0; f < 6; f++) run_frame("press", 8'h04);
    check("press_held_value", 8'(kbd.value), 8'd3);

    // Short release then re-press: note kept, no event.
    run_frame("rel_short", 8'h00);
    run_frame("rel_short", 8'h00);
    run_frame("repress", 8'h04);
    // Full release.
    for (int f = 0; f < 4; f++) run_frame("release", 8'h00);
    check("release_value", 8'(kbd.value), 8'd0);

    // Bounce: present/absent alternating frames.
    for (int f = 0; f < 6; f++) run_frame("bounce", (f % 2 == 0) ? 8'h04 : 8'h00);

    // Multi-key: positions 1 and 5.
    for (int f = 0; f < 5; f++) run_frame("multi", 8'h22);
`ifdef KEYSCAN_GHOST_REJECT_EN
    check("multi_value", 8'(kbd.value), 8'd0);
`else
    check("multi_value", 8'(kbd.value), 8'd2);
`endif
    for (int f = 0; f < 4; f++) run_frame("multi_rel", 8'h00);

    // Reset in the middle of a confirm on position 4.
    run_frame("midrst_pre", 8'h10);
    run_frame("midrst_pre", 8'h10);
    hold_reset("midrst", 2);
    for (int f = 0; f < 4; f++) run_frame("midrst_post", 8'h10);
    check("midrst_value", 8'(kbd.value), 8'd5);
    for (int f = 0; f < 4; f++) run_frame("midrst_rel", 8'h00);

    // Randomised runs of frames.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] keys;
      int len;
      case ($urandom_range(0, 5))
        0:       keys = 8'h00;
        1, 2, 3: keys = 8'(1 << $urandom_range(0, 7));
        4:       keys = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
        default: keys = 8'($urandom_range(0, 255));
      endcase
      len = $urandom_range(1, 6);
      for (int f = 0; f < len; f++) run_frame("random", keys);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
